// File: rtl/dot_job_scheduler.sv
// dot_job_scheduler
//   Shares one mac_core between two job requesters. Each job (base, len)
//   is granted round-robin, the MAC is cleared, len operand pairs are read
//   from the dual-port A/B memory (addresses wrap), the MAC pipeline is
//   drained and the result is returned over a valid/ready response channel.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         job handshake for requester N (N = 0, 1)
//   reqN_base, reqN_len      first element address, element count 0..2^AW
//   rd_en, rd_addr           operand memory read (same address for A and B)
//   rd_a, rd_b               read data, valid one cycle after rd_en
//   mac_clr, mac_en          MAC clear / accumulate enable
//   mac_b, mac_c             MAC operands (pass-through of rd_a/rd_b)
//   mac_acc, mac_oflo        MAC accumulator and sticky overflow
//   rsp_valid/ready          result handshake
//   rsp_id, rsp_acc, rsp_oflo result owner, value, overflow flag
//   busy                     high whenever the scheduler is not idle
module dot_job_scheduler #(
    parameter int W    = 8,
    parameter int ACCW = 16,
    parameter int AW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [AW-1:0]   req0_base,
    input  logic [AW:0]     req0_len,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [AW-1:0]   req1_base,
    input  logic [AW:0]     req1_len,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [W-1:0]    rd_a,
    input  logic [W-1:0]    rd_b,
    output logic            mac_clr,
    output logic            mac_en,
    output logic [W-1:0]    mac_b,
    output logic [W-1:0]    mac_c,
    input  logic [ACCW-1:0] mac_acc,
    input  logic            mac_oflo,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [ACCW-1:0] rsp_acc,
    output logic            rsp_oflo,
    output logic            busy
);

    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN1, DRAIN2, RESP} state_t;

    localparam logic [AW:0] ONE = 1;

    state_t          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW:0]     len_q, len_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            id_q, id_d;
    logic            pref_q, pref_d;     // requester favoured on a tie
    logic            mac_en_q;
    logic [ACCW-1:0] rsp_acc_q, rsp_acc_d;
    logic            rsp_oflo_q, rsp_oflo_d;
    logic            rsp_id_q, rsp_id_d;
    logic            gnt0, gnt1;

    // Requester 1 wins only if requester 0 is absent or it is its turn.
    assign gnt1 = req1_valid && (!req0_valid || pref_q);
    assign gnt0 = req0_valid && !gnt1;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        pref_d     = pref_q;
        rsp_acc_d  = rsp_acc_q;
        rsp_oflo_d = rsp_oflo_q;
        rsp_id_d   = rsp_id_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        mac_clr    = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = gnt0;
                req1_ready = gnt1;
                if (gnt0 || gnt1) begin
                    base_d  = gnt1 ? req1_base : req0_base;
                    len_d   = gnt1 ? req1_len  : req0_len;
                    id_d    = gnt1;
                    pref_d  = !gnt1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                mac_clr = 1'b1;
                cnt_d   = '0;
                state_d = (len_q != '0) ? ISSUE : DRAIN1;
            end
            ISSUE: begin
                rd_en   = 1'b1;
                rd_addr = base_q + cnt_q[AW-1:0];   // wraps mod 2^AW
                cnt_d   = cnt_q + ONE;
                if (cnt_q == len_q - ONE) state_d = DRAIN1;
            end
            DRAIN1: state_d = DRAIN2;
            DRAIN2: begin
                // Last accumulate landed at the end of DRAIN1.
                rsp_acc_d  = mac_acc;
                rsp_oflo_d = mac_oflo;
                rsp_id_d   = id_q;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            id_q       <= 1'b0;
            pref_q     <= 1'b0;
            mac_en_q   <= 1'b0;
            rsp_acc_q  <= '0;
            rsp_oflo_q <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            pref_q     <= pref_d;
            mac_en_q   <= rd_en;   // aligns with the one-cycle read latency
            rsp_acc_q  <= rsp_acc_d;
            rsp_oflo_q <= rsp_oflo_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign mac_en   = mac_en_q;
    assign mac_b    = rd_a;
    assign mac_c    = rd_b;
    assign rsp_acc  = rsp_acc_q;
    assign rsp_oflo = rsp_oflo_q;
    assign rsp_id   = rsp_id_q;
    assign busy     = (state_q != IDLE);

endmodule
